oxi_multi_ch_calib_ctrl: RTL and testbench
==========================================

// Module: oxi_multi_ch_calib_ctrl
// PURPOSE
//  Parametrised N-channel LED/AFE calibration and acquisition controller for the pulse-oximeter front end.
//  For each LED channel in turn it searches the DC-compensation DAC code, then the largest non-clipping PGA gain.
//  It then time-multiplexes the LEDs round-robin, applies each channel's stored settings and captures per-channel ADC values.
//  Sits between the ADC input and the AFE control pins (LED drive enables, DC_Comp DAC, PGA, filter clock).
// PARAMETERS
//  N_CH        2    number of LED channels (ch0=RED, ch1=IR by convention); 1..8
//  ADC_W       8    ADC sample width
//  DC_W        7    DC-compensation code width
//  PGA_W       4    PGA gain code width
//  DC_INIT     127  DC_Comp start code for every channel's search
//  DC_STEP_DN  4    DC_Comp decrement when window average < MID_LO
//  DC_STEP_UP  3    DC_Comp increment when window average > MID_HI
//  MID_LO      116  lower bound of accepted DC average (inclusive)
//  MID_HI      140  upper bound of accepted DC average (inclusive)
//  CLIP_LO     10   PGA window min must be > CLIP_LO to count as unclipped
//  CLIP_HI     245  PGA window max must be < CLIP_HI to count as unclipped
//  DC_WIN      20   samples (cycles) per DC evaluation window
//  PGA_WIN     500  samples (cycles) per PGA evaluation window
//  SLOT_CYC    10   cycles per LED slot in operation (10 ms at 1 kHz CLK)
// PORTS
//  CLK           in   1            system clock; one ADC sample per cycle
//  rst_n         in   1            asynchronous active-low reset
//  ADC           in   ADC_W        current ADC sample
//  Find_Setting  in   1            synchronous restart of calibration; highest priority
//  LED_EN        out  N_CH         one-hot LED enable (all zero in INIT)
//  DC_Comp       out  DC_W         DC-compensation DAC code
//  PGA_Gain      out  PGA_W        PGA gain code
//  CLK_Filter    out  1            CLK/2 filter clock
//  CH_Value      out  N_CH*ADC_W   last sample per channel; ch c at bits [c*ADC_W +: ADC_W]
//  CH_Valid      out  N_CH         1-cycle pulse when CH_Value slice c is updated at slot end
//  Cal_Busy      out  1            high in DC_SEARCH/PGA_SEARCH
//  Cal_Done      out  1            high in OPERATE
//  DC_Sat        out  N_CH         sticky per channel: DC search ended at a code rail
// BEHAVIOUR
//  Reset: LED_EN=0, DC_Comp=DC_INIT, PGA_Gain=0, CLK_Filter=0, CH_Value=0, CH_Valid=0, Cal_*=0, DC_Sat=0,
//   stored settings=0, state=INIT. CLK_Filter toggles every cycle after reset.
//  Find_Setting=1 in any state -> state=INIT next cycle; overrides all other transitions. Its effect matches reset,
//   except CLK_Filter keeps toggling and CH_Value is held.
//  INIT (1 cycle): DC_Comp=DC_INIT, PGA_Gain=0, ch=0, counters cleared, min/max = all-ones/0, DC_Sat=0 -> DC_SEARCH.
//  DC_SEARCH: LED_EN=1<<ch. Track min/max over DC_WIN samples. At window end compute avg=(max+min)>>1 (ADC_W+1 bit add).
//   - avg<MID_LO: DC_Comp -= DC_STEP_DN, saturating at 0.
//   - avg>MID_HI: DC_Comp += DC_STEP_UP, saturating at 2^DC_W-1.
//   - Otherwise store dc[ch]=DC_Comp, PGA_Gain=1 -> PGA_SEARCH.
//   - Move needed but DC_Comp already at the rail: store rail code, set DC_Sat[ch], PGA_Gain=1 -> PGA_SEARCH.
//   - Reset min/max after every window.
//  PGA_SEARCH: track min/max over PGA_WIN samples. At window end:
//   - min>CLIP_LO and max<CLIP_HI and PGA_Gain<max code: PGA_Gain += 1, new window.
//   - Unclipped at max code: store pga[ch]=max code.
//   - Clipped: store pga[ch]=PGA_Gain-1. Gain starts at 1, so the result is >= 0.
//   - After storing: if ch<N_CH-1 then ch+=1, DC_Comp=DC_INIT, PGA_Gain=0 -> DC_SEARCH;
//     else ch=0 -> OPERATE.
//  OPERATE: round-robin slots of SLOT_CYC cycles.
//   - Slot cycle 0: LED_EN=1<<ch, DC_Comp=dc[ch], PGA_Gain=pga[ch]. No capture on the switch cycle.
//   - Cycles 1..SLOT_CYC-1: capture ADC into a holding register.
//   - Last cycle: write the holding register to CH_Value slice ch and pulse CH_Valid[ch], then ch wraps to 0 after N_CH-1.
//  Settings and outputs change on the CLK edge only; no combinational path from ADC to any output.
// CONFIGURATION
//  CAL_TIMEOUT_EN defined:
//   - Adds parameter CAL_TMO (default 8192) and output Cal_Err (1 bit, reset 0), plus state ERROR.
//   - A per-channel cycle counter, cleared on channel entry, forces ERROR if it reaches CAL_TMO in DC_SEARCH/PGA_SEARCH.
//   - ERROR: LED_EN=0, Cal_Err=1, Cal_Busy=0; exit only via Find_Setting or reset.
//  CAL_TIMEOUT_EN undefined: no counter, no Cal_Err port, no ERROR state; search runs until it converges.
// STRUCTURE
//  Package oxi_ctrl_pkg: state enum (INIT, DC_SEARCH, PGA_SEARCH, OPERATE, ERROR), default threshold/step constants.
//  Sub-module oxi_peak_window: min/max tracker with a window counter and a clear input; outputs min, max and a win_end pulse.
//   One instance, shared by both searches; the window length is selected per state.
//  Stored settings: dc[N_CH], pga[N_CH] register arrays.
// TESTING
//  1. ADC model avg=f(DC_Comp) crossing 128 at code 87, N_CH=2 -> DC_Comp steps 127,123,...,87 and dc[0]=87; then same for ch1.
//  2. ADC swing scales with gain and clips at gain 6 -> pga[ch]=5, and OPERATE applies 5 in that channel's slot.
//  3. ADC fixed at 0 (avg always low) -> DC_Comp saturates at 0, DC_Sat[ch]=1, and the search proceeds to PGA.
//  4. OPERATE, N_CH=3, ADC=ch*50+7 -> LED_EN cycles 001,010,100 every 10 cycles; CH_Valid pulses on slot cycle 9; CH_Value slices 7,57,107.
//  5. Find_Setting asserted mid-PGA_SEARCH and mid-OPERATE -> next cycle INIT with LED_EN=0 and DC_Comp=127; rst_n low mid-window -> all reset values.
//  6. CAL_TIMEOUT_EN, CAL_TMO=100, non-converging ADC -> Cal_Err=1 at cycle 100 of the channel, LED_EN=0; Find_Setting clears it.

Source files
------------

// File: rtl/oxi_ctrl_pkg.sv
// Shared types and default constants for the
// pulse-oximeter calibration controller.
package oxi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_DC,
    ST_PGA,
    ST_OP
`ifdef CAL_TIMEOUT_EN
    ,
    ST_ERR
`endif
  } state_t;

  localparam int DEF_DC_INIT    = 127;
  localparam int DEF_DC_STEP_DN = 4;
  localparam int DEF_DC_STEP_UP = 3;
  localparam int DEF_MID_LO     = 116;
  localparam int DEF_MID_HI     = 140;
  localparam int DEF_CLIP_LO    = 10;
  localparam int DEF_CLIP_HI    = 245;
  localparam int DEF_DC_WIN     = 20;
  localparam int DEF_PGA_WIN    = 500;
  localparam int DEF_SLOT_CYC   = 10;
  localparam int DEF_CAL_TMO    = 8192;

endpackage

// File: rtl/oxi_peak_window.sv
// Windowed min/max tracker: i_sample, i_en, i_clr, i_len in;
// o_min/o_max include the current sample, o_win_end on last one.
module oxi_peak_window #(
  parameter int W     = 8,
  parameter int CNT_W = 9
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_len,
  input  logic [W-1:0]     i_sample,
  output logic [W-1:0]     o_min,
  output logic [W-1:0]     o_max,
  output logic             o_win_end
);

  logic [W-1:0]     r_min;
  logic [W-1:0]     r_max;
  logic [CNT_W-1:0] r_cnt;

  assign o_min = (i_sample < r_min) ? i_sample : r_min;
  assign o_max = (i_sample > r_max) ? i_sample : r_max;
  assign o_win_end = i_en &&
    (r_cnt == i_len - 1'b1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_min <= '1;
      r_max <= '0;
      r_cnt <= '0;
    end else if (i_clr || o_win_end) begin
      r_min <= '1;
      r_max <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      r_min <= o_min;
      r_max <= o_max;
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/oxi_multi_ch_calib_ctrl.sv
// N-channel LED/AFE calibration + round-robin acquisition.
// ADC/Find_Setting in; LED_EN, DC_Comp, PGA_Gain, CH_* out. Option: CAL_TIMEOUT_EN.
module oxi_multi_ch_calib_ctrl
  import oxi_ctrl_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int ADC_W      = 8,
  parameter int DC_W       = 7,
  parameter int PGA_W      = 4,
  parameter int DC_INIT    = DEF_DC_INIT,
  parameter int DC_STEP_DN = DEF_DC_STEP_DN,
  parameter int DC_STEP_UP = DEF_DC_STEP_UP,
  parameter int MID_LO     = DEF_MID_LO,
  parameter int MID_HI     = DEF_MID_HI,
  parameter int CLIP_LO    = DEF_CLIP_LO,
  parameter int CLIP_HI    = DEF_CLIP_HI,
  parameter int DC_WIN     = DEF_DC_WIN,
  parameter int PGA_WIN    = DEF_PGA_WIN,
  parameter int SLOT_CYC   = DEF_SLOT_CYC
`ifdef CAL_TIMEOUT_EN
  ,
  parameter int CAL_TMO    = DEF_CAL_TMO
`endif
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic [ADC_W-1:0]      ADC,
  input  logic                  Find_Setting,
  output logic [N_CH-1:0]       LED_EN,
  output logic [DC_W-1:0]       DC_Comp,
  output logic [PGA_W-1:0]      PGA_Gain,
  output logic                  CLK_Filter,
  output logic [N_CH*ADC_W-1:0] CH_Value,
  output logic [N_CH-1:0]       CH_Valid,
  output logic                  Cal_Busy,
  output logic                  Cal_Done,
  output logic [N_CH-1:0]       DC_Sat
`ifdef CAL_TIMEOUT_EN
  ,
  output logic                  Cal_Err
`endif
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WMAX =
    (PGA_WIN > DC_WIN) ? PGA_WIN : DC_WIN;
  localparam int CNT_W = $clog2(WMAX + 1);
  localparam int SL_W =
    (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;

  localparam logic [DC_W-1:0] LP_DC_INIT = DC_W'(DC_INIT);
  localparam logic [DC_W-1:0] LP_DC_MAX  = '1;
  localparam logic [DC_W-1:0] LP_DN = DC_W'(DC_STEP_DN);
  localparam logic [DC_W-1:0] LP_UP = DC_W'(DC_STEP_UP);
  localparam logic [PGA_W-1:0] LP_PGA_MAX = '1;
  localparam logic [ADC_W-1:0] LP_MID_LO  = ADC_W'(MID_LO);
  localparam logic [ADC_W-1:0] LP_MID_HI  = ADC_W'(MID_HI);
  localparam logic [ADC_W-1:0] LP_CLIP_LO = ADC_W'(CLIP_LO);
  localparam logic [ADC_W-1:0] LP_CLIP_HI = ADC_W'(CLIP_HI);
  localparam logic [CH_W-1:0] LP_LAST = CH_W'(N_CH - 1);
  localparam logic [SL_W-1:0] LP_SL_END = SL_W'(SLOT_CYC - 1);
  localparam logic [N_CH-1:0] LP_OH0 = N_CH'(1);

`ifdef CAL_TIMEOUT_EN
  localparam int TMO_W = $clog2(CAL_TMO + 1);
  logic [TMO_W-1:0] r_tmo;
  logic             w_tmo_hit;
`endif

  state_t           r_state;
  logic [CH_W-1:0]  r_ch;
  logic [SL_W-1:0]  r_slot;
  logic [ADC_W-1:0] r_hold;
  logic [DC_W-1:0]  r_dc  [N_CH];
  logic [PGA_W-1:0] r_pga [N_CH];

  logic [ADC_W-1:0] w_min;
  logic [ADC_W-1:0] w_max;
  logic             w_win_end;
  logic             w_en;
  logic             w_clr;
  logic [CNT_W-1:0] w_len;
  logic [ADC_W:0]   w_sum;
  logic [ADC_W-1:0] w_avg;
  logic             w_lo;
  logic             w_hi;
  logic             w_rail;
  logic             w_move;
  logic [DC_W-1:0]  w_dn_code;
  logic [DC_W-1:0]  w_up_code;
  logic             w_unclip;
  logic [PGA_W-1:0] w_pga_res;
  logic [CH_W-1:0]  w_ch_inc;
  logic [CH_W-1:0]  w_ch_nx;

  assign w_en = (r_state == ST_DC) ||
                (r_state == ST_PGA);
  assign w_clr = Find_Setting ||
                 (r_state == ST_INIT);
  assign w_len = (r_state == ST_PGA) ?
    CNT_W'(PGA_WIN) : CNT_W'(DC_WIN);

  oxi_peak_window #(
    .W     (ADC_W),
    .CNT_W (CNT_W)
  ) u_win (
    .i_clk     (CLK),
    .i_rst_n   (rst_n),
    .i_clr     (w_clr),
    .i_en      (w_en),
    .i_len     (w_len),
    .i_sample  (ADC),
    .o_min     (w_min),
    .o_max     (w_max),
    .o_win_end (w_win_end)
  );

  // Midpoint of the window's extremes, carry kept.
  assign w_sum = {1'b0, w_max} + {1'b0, w_min};
  assign w_avg = ADC_W'(w_sum >> 1);
  assign w_lo = w_avg < LP_MID_LO;
  assign w_hi = w_avg > LP_MID_HI;
  assign w_rail = (w_lo && DC_Comp == '0) ||
                  (w_hi && DC_Comp == LP_DC_MAX);
  assign w_move = (w_lo || w_hi) && !w_rail;
  assign w_dn_code = (DC_Comp < LP_DN) ?
    '0 : DC_Comp - LP_DN;
  assign w_up_code =
    (DC_Comp > LP_DC_MAX - LP_UP) ?
    LP_DC_MAX : DC_Comp + LP_UP;

  assign w_unclip = (w_min > LP_CLIP_LO) &&
                    (w_max < LP_CLIP_HI);
  assign w_pga_res = w_unclip ?
    LP_PGA_MAX : PGA_Gain - 1'b1;

  assign w_ch_inc = r_ch + 1'b1;
  assign w_ch_nx = (r_ch == LP_LAST) ? '0 : w_ch_inc;

`ifdef CAL_TIMEOUT_EN
  assign w_tmo_hit = w_en &&
    (r_tmo == TMO_W'(CAL_TMO - 1));
`endif

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) CLK_Filter <= 1'b0;
    else        CLK_Filter <= ~CLK_Filter;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_INIT;
      r_ch     <= '0;
      r_slot   <= '0;
      r_hold   <= '0;
      r_dc     <= '{default: '0};
      r_pga    <= '{default: '0};
      LED_EN   <= '0;
      DC_Comp  <= LP_DC_INIT;
      PGA_Gain <= '0;
      CH_Value <= '0;
      CH_Valid <= '0;
      Cal_Busy <= 1'b0;
      Cal_Done <= 1'b0;
      DC_Sat   <= '0;
`ifdef CAL_TIMEOUT_EN
      r_tmo    <= '0;
      Cal_Err  <= 1'b0;
`endif
    end else if (Find_Setting) begin
      r_state  <= ST_INIT;
      r_ch     <= '0;
      r_slot   <= '0;
      r_hold   <= '0;
      r_dc     <= '{default: '0};
      r_pga    <= '{default: '0};
      LED_EN   <= '0;
      DC_Comp  <= LP_DC_INIT;
      PGA_Gain <= '0;
      CH_Valid <= '0;
      Cal_Busy <= 1'b0;
      Cal_Done <= 1'b0;
      DC_Sat   <= '0;
`ifdef CAL_TIMEOUT_EN
      r_tmo    <= '0;
      Cal_Err  <= 1'b0;
`endif
    end else begin
      CH_Valid <= '0;
      unique case (r_state)
        ST_INIT: begin
          DC_Comp  <= LP_DC_INIT;
          PGA_Gain <= '0;
          r_ch     <= '0;
          r_slot   <= '0;
          DC_Sat   <= '0;
          LED_EN   <= LP_OH0;
          Cal_Busy <= 1'b1;
          r_state  <= ST_DC;
`ifdef CAL_TIMEOUT_EN
          r_tmo    <= '0;
`endif
        end
        ST_DC: begin
`ifdef CAL_TIMEOUT_EN
          r_tmo <= r_tmo + 1'b1;
          if (w_tmo_hit) begin
            LED_EN   <= '0;
            Cal_Busy <= 1'b0;
            Cal_Err  <= 1'b1;
            r_state  <= ST_ERR;
          end else
`endif
          if (w_win_end) begin
            if (w_move) begin
              DC_Comp <= w_lo ? w_dn_code : w_up_code;
            end else begin
              r_dc[r_ch] <= DC_Comp;
              PGA_Gain   <= 1;
              r_state    <= ST_PGA;
              if (w_rail) DC_Sat[r_ch] <= 1'b1;
            end
          end
        end
        ST_PGA: begin
`ifdef CAL_TIMEOUT_EN
          r_tmo <= r_tmo + 1'b1;
          if (w_tmo_hit) begin
            LED_EN   <= '0;
            Cal_Busy <= 1'b0;
            Cal_Err  <= 1'b1;
            r_state  <= ST_ERR;
          end else
`endif
          if (w_win_end) begin
            if (w_unclip && PGA_Gain != LP_PGA_MAX) begin
              PGA_Gain <= PGA_Gain + 1'b1;
            end else begin
              r_pga[r_ch] <= w_pga_res;
              if (r_ch != LP_LAST) begin
                r_ch     <= w_ch_inc;
                DC_Comp  <= LP_DC_INIT;
                PGA_Gain <= '0;
                LED_EN   <= LP_OH0 << w_ch_inc;
                r_state  <= ST_DC;
`ifdef CAL_TIMEOUT_EN
                r_tmo    <= '0;
`endif
              end else begin
                // Preload slot 0 so ch0 settings are live on its
                // first cycle; with one channel the gain is the
                // value being stored right now.
                r_ch     <= '0;
                r_slot   <= '0;
                LED_EN   <= LP_OH0;
                DC_Comp  <= r_dc[0];
                PGA_Gain <= (N_CH == 1) ?
                  w_pga_res : r_pga[0];
                Cal_Busy <= 1'b0;
                Cal_Done <= 1'b1;
                r_state  <= ST_OP;
              end
            end
          end
        end
        ST_OP: begin
          if (r_slot != '0) r_hold <= ADC;
          if (r_slot == LP_SL_END) begin
            CH_Value[r_ch*ADC_W +: ADC_W] <= r_hold;
            CH_Valid[r_ch] <= 1'b1;
            r_ch     <= w_ch_nx;
            r_slot   <= '0;
            LED_EN   <= LP_OH0 << w_ch_nx;
            DC_Comp  <= r_dc[w_ch_nx];
            PGA_Gain <= r_pga[w_ch_nx];
          end else begin
            r_slot <= r_slot + 1'b1;
          end
        end
`ifdef CAL_TIMEOUT_EN
        ST_ERR: begin
          LED_EN <= '0;
        end
`endif
        default: r_state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_oxi_multi_ch_calib_ctrl.sv
// Directed bench for oxi_multi_ch_calib_ctrl (3 channels).
// Scoreboard queues hold expected DC steps and slot captures.
module tb_oxi_multi_ch_calib_ctrl;

  localparam int N = 3;

  logic          CLK = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    ADC = '0;
  logic          Find_Setting = 1'b0;
  logic [N-1:0]  LED_EN;
  logic [6:0]    DC_Comp;
  logic [3:0]    PGA_Gain;
  logic          CLK_Filter;
  logic [N*8-1:0] CH_Value;
  logic [N-1:0]  CH_Valid;
  logic          Cal_Busy;
  logic          Cal_Done;
  logic [N-1:0]  DC_Sat;
`ifdef CAL_TIMEOUT_EN
  logic          Cal_Err;
`endif

  oxi_multi_ch_calib_ctrl #(
    .N_CH (N)
`ifdef CAL_TIMEOUT_EN
    ,
    .CAL_TMO (100)
`endif
  ) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .ADC          (ADC),
    .Find_Setting (Find_Setting),
    .LED_EN       (LED_EN),
    .DC_Comp      (DC_Comp),
    .PGA_Gain     (PGA_Gain),
    .CLK_Filter   (CLK_Filter),
    .CH_Value     (CH_Value),
    .CH_Valid     (CH_Valid),
    .Cal_Busy     (Cal_Busy),
    .Cal_Done     (Cal_Done),
    .DC_Sat       (DC_Sat)
`ifdef CAL_TIMEOUT_EN
    ,
    .Cal_Err      (Cal_Err)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int mode = 0;
  bit ph = 1'b0;

  // mode 0: DC level crosses 128 at code 87, swing 20/gain
  // mode 1: ADC 0; mode 2: ch*50+7; mode 3: ADC 255
  function automatic logic [7:0] model();
    int v;
    int sw;
    v = 0;
    if (mode == 0) begin
      v = 128 + (87 - int'(DC_Comp)) * 4;
      sw = 20 * int'(PGA_Gain);
      v = ph ? v + sw : v - sw;
    end else if (mode == 2) begin
      for (int c = 0; c < N; c++)
        if (LED_EN[c]) v = c * 50 + 7;
    end else if (mode == 3) begin
      v = 255;
    end
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
    ph = ~ph;
    ADC = model();
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_led"}, 32'(LED_EN), 0);
    chk({tag, "_dc"}, 32'(DC_Comp), 127);
    chk({tag, "_pga"}, 32'(PGA_Gain), 0);
    chk({tag, "_cf"}, 32'(CLK_Filter), 0);
    chk({tag, "_val"}, 32'(CH_Value), 0);
    chk({tag, "_vld"}, 32'(CH_Valid), 0);
    chk({tag, "_busy"}, 32'(Cal_Busy), 0);
    chk({tag, "_done"}, 32'(Cal_Done), 0);
    chk({tag, "_sat"}, 32'(DC_Sat), 0);
  endtask

  logic [6:0]  q_dc [$];
  logic [31:0] q_op [$];

  initial begin
    int n;
    int last;
    logic [6:0] prev;
    logic [6:0] edc;
    logic [31:0] eop;
    logic [3:0] gmax;

    step();
    step();
    chk_reset("rst0");
    rst_n = 1'b1;
    step();
    chk("start_led", 32'(LED_EN), 1);
    chk("start_busy", 32'(Cal_Busy), 1);
    chk("start_cf", 32'(CLK_Filter), 1);

`ifdef CAL_TIMEOUT_EN
    mode = 1;
    ADC = model();
    repeat (99) step();
    chk("tmo_pre", 32'(Cal_Err), 0);
    step();
    chk("tmo_err", 32'(Cal_Err), 1);
    chk("tmo_led", 32'(LED_EN), 0);
    chk("tmo_busy", 32'(Cal_Busy), 0);
    repeat (5) step();
    chk("tmo_hold", 32'(Cal_Err), 1);
    Find_Setting = 1'b1;
    step();
    chk("tmo_clr", 32'(Cal_Err), 0);
    chk("tmo_clr_dc", 32'(DC_Comp), 127);
    Find_Setting = 1'b0;
    step();
    chk("tmo_rst_led", 32'(LED_EN), 1);
    chk("tmo_rst_busy", 32'(Cal_Busy), 1);
`else
    for (int k = 1; k <= 10; k++)
      q_dc.push_back(7'(127 - 4 * k));
    prev = DC_Comp;
    n = 0;
    while (PGA_Gain != 4'd1 && n < 1000) begin
      step();
      n++;
      if (DC_Comp != prev) begin
        if (q_dc.size() > 0) begin
          edc = q_dc.pop_front();
          chk("dc_step", 32'(DC_Comp), 32'(edc));
        end else begin
          chk("dc_extra", 32'(DC_Comp), 32'(prev));
        end
        prev = DC_Comp;
      end
    end
    chk("dc_cycles", n, 220);
    chk("dc_left", q_dc.size(), 0);
    chk("dc_final", 32'(DC_Comp), 87);
    chk("dc_nosat", 32'(DC_Sat), 0);

    n = 0;
    gmax = 0;
    while (DC_Comp != 7'd127 && n < 5000) begin
      step();
      n++;
      if (PGA_Gain > gmax) gmax = PGA_Gain;
    end
    chk("pga_cycles", n, 3000);
    chk("pga_gmax", 32'(gmax), 6);
    chk("ch1_led", 32'(LED_EN), 2);
    chk("ch1_pga", 32'(PGA_Gain), 0);

    n = 0;
    while (!Cal_Done && n < 10000) begin
      step();
      n++;
    end
    chk("done_seen", 32'(Cal_Done), 1);
    chk("op_led0", 32'(LED_EN), 1);
    chk("op_dc0", 32'(DC_Comp), 87);
    chk("op_pga0", 32'(PGA_Gain), 5);
    chk("op_busy", 32'(Cal_Busy), 0);

    mode = 2;
    ADC = model();
    for (int s = 0; s < 6; s++)
      q_op.push_back({16'(s % N), 16'((s % N) * 50 + 7)});
    n = 0;
    last = 0;
    while (q_op.size() > 0 && n < 100) begin
      step();
      n++;
      if (CH_Valid != '0) begin
        eop = q_op.pop_front();
        chk("op_vld", 32'(CH_Valid), 32'(1 << eop[31:16]));
        chk("op_val",
            32'(CH_Value[eop[31:16]*8 +: 8]),
            32'(eop[15:0]));
        chk("op_period", n - last, 10);
        chk("op_led_nx", 32'(LED_EN),
            32'(1 << ((eop[31:16] + 1) % N)));
        chk("op_pga", 32'(PGA_Gain), 5);
        last = n;
      end
    end
    chk("op_left", q_op.size(), 0);

    Find_Setting = 1'b1;
    step();
    chk("fs_op_led", 32'(LED_EN), 0);
    chk("fs_op_dc", 32'(DC_Comp), 127);
    chk("fs_op_done", 32'(Cal_Done), 0);
    chk("fs_op_hold", 32'(CH_Value),
        {8'd107, 8'd57, 8'd7});

    mode = 1;
    Find_Setting = 1'b0;
    ADC = model();
    step();
    n = 0;
    while (PGA_Gain != 4'd1 && n < 2000) begin
      step();
      n++;
    end
    chk("sat_cycles", n, 660);
    chk("sat_dc", 32'(DC_Comp), 0);
    chk("sat_flag", 32'(DC_Sat), 1);

    repeat (100) step();
    chk("sat_in_pga", 32'(Cal_Busy), 1);
    Find_Setting = 1'b1;
    step();
    chk("fs_pga_led", 32'(LED_EN), 0);
    chk("fs_pga_dc", 32'(DC_Comp), 127);
    chk("fs_pga_gain", 32'(PGA_Gain), 0);
    chk("fs_pga_sat", 32'(DC_Sat), 0);
    chk("fs_pga_busy", 32'(Cal_Busy), 0);

    mode = 3;
    Find_Setting = 1'b0;
    ADC = model();
    step();
    n = 0;
    while (PGA_Gain != 4'd1 && n < 200) begin
      step();
      n++;
    end
    chk("hi_cycles", n, 20);
    chk("hi_dc", 32'(DC_Comp), 127);
    chk("hi_sat", 32'(DC_Sat), 1);
`endif

    repeat (7) step();
    rst_n = 1'b0;
    #1;
    chk_reset("rst1");
    step();
    rst_n = 1'b1;
    step();
    chk("rst1_led", 32'(LED_EN), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
